// File: rtl/can_access_arbiter_pkg.sv
// Shared definitions for the Canakari access arbiter and both requesting state machines:
// op codes, one-hot state/debug codes and op decode helpers.
package can_access_arbiter_pkg;

  localparam logic [1:0] OP_READ    = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_SEND    = 2'b10;
  localparam logic [1:0] OP_RST_IRQ = 2'b11;

  // State values double as the statedeb debug codes.
  typedef enum logic [7:0] {
    ST_IDLE      = 8'h01,
    ST_GRANT     = 8'h02,
    ST_ISSUE     = 8'h04,
    ST_WAIT_DONE = 8'h08,
    ST_RELEASE   = 8'h10,
    ST_ABORT     = 8'h20
  } arb_state_e;

  // Command vector order: {start_read, start_write, send_mes, reset_irq_can}.
  function automatic logic [3:0] op_to_cmd(input logic [1:0] op);
    logic [3:0] cmd;
    case (op)
      OP_READ:    cmd = 4'b1000;
      OP_WRITE:   cmd = 4'b0100;
      OP_SEND:    cmd = 4'b0010;
      OP_RST_IRQ: cmd = 4'b0001;
      default:    cmd = 4'b0000;
    endcase
    return cmd;
  endfunction

  function automatic logic op_complete(input logic [1:0] op, input logic end_read,
                                       input logic end_write, input logic end_send,
                                       input logic rst_done);
    logic hit;
    case (op)
      OP_READ:    hit = end_read;
      OP_WRITE:   hit = end_write;
      OP_SEND:    hit = end_send;
      OP_RST_IRQ: hit = rst_done;
      default:    hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/can_access_arbiter_timeout_counter.sv
// WAIT_DONE watchdog counter: cleared outside WAIT_DONE, counts while enabled and
// flags the cycle at which the count reaches TERMINAL-1.
module arb_timeout_counter #(
  parameter logic [31:0] TERMINAL = 32'd1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc
);

  logic [31:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 32'd0;
    end else if (i_clr) begin
      r_count <= 32'd0;
    end else if (i_en) begin
      r_count <= r_count + 32'd1;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_tc = i_en && (r_count == (TERMINAL - 32'd1));

endmodule

// File: rtl/can_access_arbiter.sv
// Grants the Canakari interface to the main or trim state machine, one operation at a time.
// Optional watchdog abort of stuck operations is built when ARB_TIMEOUT_EN is defined.
module can_access_arbiter
  import can_access_arbiter_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_main,
  input  logic       req_trim,
  input  logic       osc_trim_mode,
  input  logic       go_main,
  input  logic       go_trim,
  input  logic [1:0] op_main,
  input  logic [1:0] op_trim,
  input  logic       end_read,
  input  logic       end_write,
  input  logic       end_send,
  input  logic       reset_irq_can_done,
  output logic       gnt_main,
  output logic       gnt_trim,
  output logic       start_read,
  output logic       start_write,
  output logic       send_mes,
  output logic       reset_irq_can,
  output logic       done_main,
  output logic       done_trim,
  output logic       abort_arb,
  output logic       timeout_err,
  output logic       busy,
  output logic [7:0] statedeb
);

  arb_state_e r_state, w_next_state;
  logic       r_owner_trim, w_next_owner_trim;
  logic       r_last_trim, w_next_last_trim;
  logic [1:0] r_op, w_next_op;
  logic       r_gnt_main, r_gnt_trim, r_done_main, r_done_trim, r_busy;
  logic [3:0] r_cmd, w_cmd;
  logic       w_done, w_abort, w_granted, w_tc;
  logic       w_owner_req, w_owner_go;
  logic [1:0] w_owner_op;

  assign w_owner_req = r_owner_trim ? req_trim : req_main;
  assign w_owner_go  = r_owner_trim ? go_trim  : go_main;
  assign w_owner_op  = r_owner_trim ? op_trim  : op_main;

`ifdef ARB_TIMEOUT_EN
  logic r_abort, r_timeout_err;

  arb_timeout_counter #(.TERMINAL(TIMEOUT_CYCLES)) u_timeout (
    .clk  (clk),
    .rst  (rst),
    .i_en (r_state == ST_WAIT_DONE),
    .i_clr(r_state != ST_WAIT_DONE),
    .o_tc (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_abort       <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_abort       <= w_abort;
      r_timeout_err <= w_abort;
    end
  end

  assign abort_arb   = r_abort;
  assign timeout_err = r_timeout_err;
`else
  logic w_unused;

  assign w_tc        = 1'b0;
  assign abort_arb   = 1'b0;
  assign timeout_err = 1'b0;
  assign w_unused    = w_abort ^ (^TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner_trim <= 1'b0;
      r_last_trim  <= 1'b1;
      r_op         <= OP_READ;
      r_gnt_main   <= 1'b0;
      r_gnt_trim   <= 1'b0;
      r_cmd        <= 4'b0000;
      r_done_main  <= 1'b0;
      r_done_trim  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_owner_trim <= w_next_owner_trim;
      r_last_trim  <= w_next_last_trim;
      r_op         <= w_next_op;
      r_gnt_main   <= w_granted & ~w_next_owner_trim;
      r_gnt_trim   <= w_granted & w_next_owner_trim;
      r_cmd        <= w_cmd;
      r_done_main  <= w_done & ~r_owner_trim;
      r_done_trim  <= w_done & r_owner_trim;
      r_busy       <= (w_next_state != ST_IDLE);
    end
  end

  always_comb begin
    w_next_state      = r_state;
    w_next_owner_trim = r_owner_trim;
    w_next_last_trim  = r_last_trim;
    w_next_op         = r_op;
    w_done            = 1'b0;
    w_abort           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Contention: trim mode forces trim, otherwise whoever was not granted last.
        if (req_main && req_trim) begin
          w_next_owner_trim = osc_trim_mode ? 1'b1 : ~r_last_trim;
          w_next_state      = ST_GRANT;
        end else if (req_main || req_trim) begin
          w_next_owner_trim = req_trim;
          w_next_state      = ST_GRANT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (w_owner_go) begin
          w_next_op    = w_owner_op;
          w_next_state = ST_ISSUE;
        end else if (!w_owner_req) begin
          w_next_state = ST_RELEASE;
        end else begin
          w_next_state = ST_GRANT;
        end
      end
      ST_ISSUE: begin
        w_next_state = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // A completion on the terminal-count cycle takes precedence over the abort.
        if (op_complete(r_op, end_read, end_write, end_send, reset_irq_can_done)) begin
          w_done       = 1'b1;
          w_next_state = ST_GRANT;
        end else if (w_tc) begin
          w_done       = 1'b1;
          w_abort      = 1'b1;
          w_next_state = ST_ABORT;
        end else begin
          w_next_state = ST_WAIT_DONE;
        end
      end
      ST_ABORT: begin
        w_next_state = ST_GRANT;
      end
      ST_RELEASE: begin
        w_next_last_trim = r_owner_trim;
        w_next_state     = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_cmd     = 4'b0000;
    w_granted = 1'b0;
    if (w_next_state == ST_ISSUE) begin
      w_cmd = op_to_cmd(w_next_op);
    end else begin
      w_cmd = 4'b0000;
    end
    if ((w_next_state == ST_IDLE) || (w_next_state == ST_RELEASE)) begin
      w_granted = 1'b0;
    end else begin
      w_granted = 1'b1;
    end
  end

  assign gnt_main      = r_gnt_main;
  assign gnt_trim      = r_gnt_trim;
  assign start_read    = r_cmd[3];
  assign start_write   = r_cmd[2];
  assign send_mes      = r_cmd[1];
  assign reset_irq_can = r_cmd[0];
  assign done_main     = r_done_main;
  assign done_trim     = r_done_trim;
  assign busy          = r_busy;
  assign statedeb      = r_state;

endmodule

// File: tb/tb_can_access_arbiter.sv
// Self-checking bench for can_access_arbiter: directed scenarios plus randomized
// request/op sequences checked against a transaction-level model of the arbitration rules.
module tb_can_access_arbiter;

  localparam logic [31:0] TO = 32'd16;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_main, req_trim, osc_trim_mode, go_main, go_trim;
  logic [1:0] op_main, op_trim;
  logic       end_read, end_write, end_send, reset_irq_can_done;
  logic       gnt_main, gnt_trim, start_read, start_write, send_mes, reset_irq_can;
  logic       done_main, done_trim, abort_arb, timeout_err, busy;
  logic [7:0] statedeb;
  logic [10:0] obs;

  int checks = 0;
  int errors = 0;
  bit m_last_trim;

  always #5 clk = ~clk;

  can_access_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_main(req_main), .req_trim(req_trim),
    .osc_trim_mode(osc_trim_mode), .go_main(go_main), .go_trim(go_trim),
    .op_main(op_main), .op_trim(op_trim), .end_read(end_read), .end_write(end_write),
    .end_send(end_send), .reset_irq_can_done(reset_irq_can_done),
    .gnt_main(gnt_main), .gnt_trim(gnt_trim), .start_read(start_read),
    .start_write(start_write), .send_mes(send_mes), .reset_irq_can(reset_irq_can),
    .done_main(done_main), .done_trim(done_trim), .abort_arb(abort_arb),
    .timeout_err(timeout_err), .busy(busy), .statedeb(statedeb)
  );

  assign obs = {gnt_main, gnt_trim, start_read, start_write, send_mes, reset_irq_can,
                done_main, done_trim, abort_arb, timeout_err, busy};

  // Expected output vector in the same order as obs.
  function automatic logic [10:0] ev(bit gm, bit gt, logic [3:0] cmd, bit dm, bit dt,
                                     bit ab, bit te, bit bz);
    return {gm, gt, cmd, dm, dt, ab, te, bz};
  endfunction

  function automatic logic [3:0] cmd_of(logic [1:0] op);
    logic [3:0] v;
    v = 4'b1000;
    return v >> op;
  endfunction

  function automatic bit winner_trim(bit rm, bit rt, bit mode, bit last_trim);
    if (rm && rt) return mode ? 1'b1 : !last_trim;
    return rt;
  endfunction

  task automatic idle_inputs();
    req_main = 1'b0; req_trim = 1'b0; osc_trim_mode = 1'b0;
    go_main = 1'b0; go_trim = 1'b0; op_main = 2'b00; op_trim = 2'b00;
    end_read = 1'b0; end_write = 1'b0; end_send = 1'b0; reset_irq_can_done = 1'b0;
  endtask

  task automatic set_end(logic [1:0] op);
    case (op)
      2'b00: end_read = 1'b1;
      2'b01: end_write = 1'b1;
      2'b10: end_send = 1'b1;
      default: reset_irq_can_done = 1'b1;
    endcase
  endtask

  task automatic clear_ends();
    end_read = 1'b0; end_write = 1'b0; end_send = 1'b0; reset_irq_can_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    m_last_trim = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One owner operation from GRANT back to GRANT; the non-owner strobes go randomly.
  task automatic run_op(bit own_t, logic [1:0] op, int delay, bit wrong_first, bit drop_req);
    logic [10:0] e;
    if (own_t) begin
      go_trim = 1'b1; op_trim = op; go_main = 1'($urandom_range(0, 1)); op_main = 2'($urandom);
      if (drop_req) req_trim = 1'b0;
    end else begin
      go_main = 1'b1; op_main = op; go_trim = 1'($urandom_range(0, 1)); op_trim = 2'($urandom);
      if (drop_req) req_main = 1'b0;
    end
    @(negedge clk);
    go_main = 1'b0; go_trim = 1'b0;
    e = ev(!own_t, own_t, cmd_of(op), 0, 0, 0, 0, 1);
    checks++;
    if (obs !== e || statedeb !== 8'h04) begin
      errors++;
      $display("FAIL issue: obs=%b state=%h expected obs=%b state=04", obs, statedeb, e);
    end
    @(negedge clk);
    e = ev(!own_t, own_t, 4'b0000, 0, 0, 0, 0, 1);
    checks++;
    if (obs !== e || statedeb !== 8'h08) begin
      errors++;
      $display("FAIL wait_entry: obs=%b state=%h expected obs=%b state=08", obs, statedeb, e);
    end
    for (int i = 0; i < delay; i++) begin
      if (wrong_first && i == 0) set_end(op + 2'd1);
      @(negedge clk);
      clear_ends();
      checks++;
      if (obs !== e || statedeb !== 8'h08) begin
        errors++;
        $display("FAIL wait_hold: obs=%b state=%h expected obs=%b state=08", obs, statedeb, e);
      end
    end
    set_end(op);
    @(negedge clk);
    clear_ends();
    e = ev(!own_t, own_t, 4'b0000, !own_t, own_t, 0, 0, 1);
    checks++;
    if (obs !== e || statedeb !== 8'h02) begin
      errors++;
      $display("FAIL done: obs=%b state=%h expected obs=%b state=02", obs, statedeb, e);
    end
  endtask

  // Owner already dropped req: expect RELEASE then IDLE.
  task automatic expect_release(bit own_t);
    @(negedge clk);
    checks++;
    if (obs !== ev(0, 0, 4'b0000, 0, 0, 0, 0, 1) || statedeb !== 8'h10) begin
      errors++;
      $display("FAIL release: obs=%b state=%h expected busy only, state=10", obs, statedeb);
    end
    m_last_trim = own_t;
    @(negedge clk);
    checks++;
    if (obs !== 11'd0 || statedeb !== 8'h01) begin
      errors++;
      $display("FAIL idle: obs=%b state=%h expected obs=0 state=01", obs, statedeb);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: obs=%b expected 0", obs);
    end
    checks++;
    if (statedeb !== 8'h01) begin
      errors++;
      $display("FAIL reset_state: statedeb=%h expected 01", statedeb);
    end
  endtask

  task automatic test_single_request();
    req_main = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== ev(1, 0, 4'b0000, 0, 0, 0, 0, 1) || statedeb !== 8'h02) begin
      errors++;
      $display("FAIL single_grant: obs=%b state=%h expected gnt_main", obs, statedeb);
    end
    run_op(1'b0, 2'b01, 4, 1'b0, 1'b0);
    req_main = 1'b0;
    expect_release(1'b0);
  endtask

  task automatic test_round_robin();
    do_reset();
    req_main = 1'b1; req_trim = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== ev(1, 0, 4'b0000, 0, 0, 0, 0, 1)) begin
      errors++;
      $display("FAIL rr_first_main: obs=%b expected gnt_main", obs);
    end
    req_main = 1'b0;
    @(negedge clk);
    req_main = 1'b1;
    checks++;
    if (statedeb !== 8'h10 || gnt_main !== 1'b0 || gnt_trim !== 1'b0) begin
      errors++;
      $display("FAIL rr_release: state=%h gnt=%b%b expected 10 with no grant", statedeb, gnt_main, gnt_trim);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (obs !== ev(0, 1, 4'b0000, 0, 0, 0, 0, 1) || statedeb !== 8'h02) begin
      errors++;
      $display("FAIL rr_then_trim: obs=%b state=%h expected gnt_trim", obs, statedeb);
    end
    req_main = 1'b0; req_trim = 1'b0;
    expect_release(1'b1);
  endtask

  task automatic test_trim_priority();
    do_reset();
    req_main = 1'b1; req_trim = 1'b1; osc_trim_mode = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== ev(0, 1, 4'b0000, 0, 0, 0, 0, 1)) begin
      errors++;
      $display("FAIL trim_priority: obs=%b expected gnt_trim", obs);
    end
    go_main = 1'b1; op_main = 2'b00;
    @(negedge clk);
    go_main = 1'b0;
    checks++;
    if (obs !== ev(0, 1, 4'b0000, 0, 0, 0, 0, 1) || statedeb !== 8'h02) begin
      errors++;
      $display("FAIL non_owner_go: obs=%b state=%h expected no command, state=02", obs, statedeb);
    end
    req_main = 1'b0; req_trim = 1'b0; osc_trim_mode = 1'b0;
    expect_release(1'b1);
  endtask

  task automatic test_completion_match();
    req_main = 1'b1;
    @(negedge clk);
    run_op(1'b0, 2'b00, 2, 1'b1, 1'b0);
    req_main = 1'b0;
    expect_release(1'b0);
  endtask

  task automatic test_go_and_drop();
    req_trim = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_trim !== 1'b1) begin
      errors++;
      $display("FAIL drop_grant: gnt_trim=%b expected 1", gnt_trim);
    end
    run_op(1'b1, 2'b11, 1, 1'b0, 1'b1);
    expect_release(1'b1);
  endtask

  task automatic test_timeout();
    logic [10:0] e;
    req_main = 1'b1;
    @(negedge clk);
    go_main = 1'b1; op_main = 2'b10;
    @(negedge clk);
    go_main = 1'b0;
    @(negedge clk);
`ifdef ARB_TIMEOUT_EN
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      e = (n == 16) ? ev(1, 0, 4'b0000, 1, 0, 1, 1, 1) : ev(1, 0, 4'b0000, 0, 0, 0, 0, 1);
      checks++;
      if (obs !== e || statedeb !== ((n == 16) ? 8'h20 : 8'h08)) begin
        errors++;
        $display("FAIL timeout_cycle%0d: obs=%b state=%h expected obs=%b", n, obs, statedeb, e);
      end
    end
    @(negedge clk);
    checks++;
    if (obs !== ev(1, 0, 4'b0000, 0, 0, 0, 0, 1) || statedeb !== 8'h02) begin
      errors++;
      $display("FAIL timeout_regrant: obs=%b state=%h expected state=02", obs, statedeb);
    end
    go_main = 1'b1; op_main = 2'b10;
    @(negedge clk);
    go_main = 1'b0;
    @(negedge clk);
    for (int n = 1; n < 16; n++) @(negedge clk);
    end_send = 1'b1;
    @(negedge clk);
    end_send = 1'b0;
    checks++;
    if (obs !== ev(1, 0, 4'b0000, 1, 0, 0, 0, 1) || statedeb !== 8'h02) begin
      errors++;
      $display("FAIL done_beats_timeout: obs=%b state=%h expected done only", obs, statedeb);
    end
`else
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      checks++;
      if (obs !== ev(1, 0, 4'b0000, 0, 0, 0, 0, 1) || statedeb !== 8'h08) begin
        errors++;
        $display("FAIL no_timeout_cycle%0d: obs=%b state=%h expected wait", n, obs, statedeb);
      end
    end
    end_send = 1'b1;
    @(negedge clk);
    end_send = 1'b0;
    checks++;
    if (obs !== ev(1, 0, 4'b0000, 1, 0, 0, 0, 1)) begin
      errors++;
      $display("FAIL late_done: obs=%b expected done_main", obs);
    end
`endif
    req_main = 1'b0;
    expect_release(1'b0);
  endtask

  task automatic test_reset_mid_op();
    req_main = 1'b1;
    @(negedge clk);
    go_main = 1'b1; op_main = 2'b00;
    @(negedge clk);
    go_main = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== 11'd0 || statedeb !== 8'h01) begin
      errors++;
      $display("FAIL async_reset: obs=%b state=%h expected obs=0 state=01", obs, statedeb);
    end
    @(negedge clk);
    rst = 1'b0; req_main = 1'b0; m_last_trim = 1'b1;
    end_read = 1'b1;
    @(negedge clk);
    end_read = 1'b0;
    for (int n = 0; n < 2; n++) begin
      checks++;
      if (obs !== 11'd0 || statedeb !== 8'h01) begin
        errors++;
        $display("FAIL lost_op: obs=%b state=%h expected idle, no done", obs, statedeb);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    bit rm, rt, w;
    int r, nops, dly;
    logic [1:0] op;
    for (int it = 0; it < 24; it++) begin
      r = $urandom_range(1, 3);
      rm = r[0]; rt = r[1];
      osc_trim_mode = 1'($urandom_range(0, 1));
      req_main = rm; req_trim = rt;
      w = winner_trim(rm, rt, osc_trim_mode, m_last_trim);
      @(negedge clk);
      checks++;
      if (obs !== ev(!w, w, 4'b0000, 0, 0, 0, 0, 1) || statedeb !== 8'h02) begin
        errors++;
        $display("FAIL rand_grant%0d: obs=%b state=%h expected owner trim=%0d", it, obs, statedeb, w);
      end
      nops = $urandom_range(1, 3);
      for (int k = 0; k < nops; k++) begin
        op = 2'($urandom);
        dly = $urandom_range(0, 4);
        run_op(w, op, dly, (dly > 0) && ($urandom_range(0, 1) == 1), 1'b0);
      end
      if (w) req_trim = 1'b0;
      else req_main = 1'b0;
      expect_release(w);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    m_last_trim = 1'b1;
    test_reset();
    test_single_request();
    test_round_robin();
    test_trim_priority();
    test_completion_match();
    test_go_and_drop();
    test_timeout();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/can_access_arbiter.md
# can_access_arbiter

Arbitrates exclusive access to the shared Canakari interface between the two command sources in the bridge controller: the CAN/e-link bridge state machine (main) and the oscillator trim state machine (trim). It replaces direct OR-ing of their start/send/reset strobes with a granted, one-operation-at-a-time sequence. It returns a completion pulse only to the owner of the operation and optionally aborts operations that never complete. Sits between both state machines and the Canakari interface inside the bridge controller.

## Interface
- TIMEOUT_CYCLES, 32'd1000000, cycles in WAIT_DONE before abort (25 ms at 40 MHz); only used with ARB_TIMEOUT_EN.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_main, req_trim  in  1 each  level request for ownership.
- osc_trim_mode  in  1  when high, trim wins any simultaneous request.
- go_main, go_trim  in  1 each  one-cycle operation strobe from requester.
- op_main, op_trim  in  2 each  op code sampled with go: 00 read, 01 write, 10 send, 11 reset_irq.
- end_read, end_write, end_send, reset_irq_can_done  in  1 each  completion pulses from Canakari side.
- gnt_main, gnt_trim  out  1 each  ownership; never both high.
- start_read, start_write, send_mes, reset_irq_can  out  1 each  one-cycle command pulses to Canakari interface.
- done_main, done_trim  out  1 each  one-cycle completion to owner.
- abort_arb  out  1  one-cycle abort on timeout.
- timeout_err  out  1  one-cycle, coincident with done_x on a timed-out op.
- busy  out  1  high in any state except IDLE.
- statedeb  out  8  state code for debug.

## Operation
- States/statedeb codes: IDLE 0x01, GRANT 0x02, ISSUE 0x04, WAIT_DONE 0x08, RELEASE 0x10, ABORT 0x20.
- IDLE: no request -> stay. One request -> GRANT that requester. Both requesting -> trim if osc_trim_mode, else round-robin: the requester not granted last wins. After reset the last-granted pointer selects main first.
- GRANT: the owner's go latches op into op_reg -> ISSUE. The non-owner's go is ignored. Owner drops req with no go -> RELEASE.
- ISSUE: exactly one command pulse per op_reg (read->start_read, write->start_write, send->send_mes, reset_irq->reset_irq_can) -> WAIT_DONE.
- WAIT_DONE: wait for the completion matching op_reg (end_read / end_write / end_send / reset_irq_can_done). Non-matching completions are ignored. On the match, pulse done_x for the owner -> GRANT. The owner may issue further ops without re-arbitration. A req drop is ignored until the op completes.
- RELEASE: grants low for one cycle, pointer updated -> IDLE.
- ABORT (macro only): reached when the WAIT_DONE counter hits TIMEOUT_CYCLES-1. Pulses abort_arb, done_x and timeout_err together -> GRANT.
- Reset values: all outputs 0 except statedeb = 0x01. op_reg 00, counter 0, pointer = trim (so main wins first).

## Timing
- req high at edge N (IDLE) -> gnt high after edge N+1.
- go at edge N (GRANT) -> command pulse after edge N+1, for exactly one cycle.
- Matching completion at edge N -> done_x after edge N+1.
- Timeout counter clears on entry to WAIT_DONE and increments each WAIT_DONE cycle. abort_arb fires TIMEOUT_CYCLES cycles after entry.
- A completion arriving in the same cycle as the timeout terminal count wins: normal done, no abort.
- go and a req drop in the same GRANT cycle: go wins, op executes.
- Async rst mid-operation: state to IDLE immediately, no pulses emitted, a pending op is lost.

## Configuration
- ARB_TIMEOUT_EN defined: 32-bit counter, ABORT state, abort_arb and timeout_err active.
- ARB_TIMEOUT_EN undefined: no counter, WAIT_DONE waits indefinitely, abort_arb and timeout_err tied 0, TIMEOUT_CYCLES unused.

## Structure
- Shared package: op-code constants (OP_READ, OP_WRITE, OP_SEND, OP_RST_IRQ) and statedeb state codes. These are shared with both requesting state machines.
- One sub-module, arb_timeout_counter (enable, clear, terminal-count pulse), instantiated only under ARB_TIMEOUT_EN.

## Test plan
- **Single request:** req_main only, go_main op=01, end_write 5 cycles later -> gnt_main at +1, start_write one pulse, done_main one pulse, gnt_trim stays 0.
- **Round-robin:** both req, osc_trim_mode=0 from reset -> main granted. Main releases with both still requesting -> trim granted after the RELEASE cycle.
- **Trim priority:** both req with osc_trim_mode=1 -> gnt_trim. A go_main during the trim grant -> no command pulse.
- **Completion matching:** op=00 read, end_write arrives first -> ignored, stays in WAIT_DONE (statedeb 0x08). end_read then -> done pulse.
- **Timeout:** with ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, issue op=10 with no end_send -> abort_arb, timeout_err and done pulse 16 cycles after entering WAIT_DONE. Without the macro -> stays in WAIT_DONE and abort_arb stays 0.
- **Reset mid-op:** rst during WAIT_DONE -> all outputs 0 and statedeb 0x01 immediately. A later end_read produces no done.
